// File: rtl/alarm_scheduler_pkg.sv
// Shared clock/alarm types and limits.
// Used by the alarm scheduler and its match arbiter.
package alarm_scheduler_pkg;

    localparam int MIN_W  = 7;
    localparam int HOUR_W = 6;

    localparam logic [MIN_W-1:0]  MAX_MINUTES = 7'd60;
    localparam logic [HOUR_W-1:0] MAX_HOURS   = 6'd24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    typedef struct packed {
        logic              enable;
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
    } alarm_slot_t;

    function automatic logic time_valid(
        input logic [HOUR_W-1:0] h,
        input logic [MIN_W-1:0]  m
    );
        return (h < MAX_HOURS) && (m < MAX_MINUTES);
    endfunction

endpackage

// File: rtl/alarm_scheduler_match_arbiter.sv
// Compares every slot against the current time and
// picks the lowest-index hit.
module alarm_match_arbiter
    import alarm_scheduler_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = $clog2(NUM_ALARMS)
) (
    input  alarm_slot_t [NUM_ALARMS-1:0] slots,
    input  logic [HOUR_W-1:0]            cur_hours,
    input  logic [MIN_W-1:0]             cur_minutes,
    input  logic                         time_chg,
    output logic                         match_valid,
    output logic [IDX_W-1:0]             match_idx
);

    logic [NUM_ALARMS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit[i] = time_chg
                   && slots[i].enable
                   && (slots[i].hours == cur_hours)
                   && (slots[i].minutes == cur_minutes);
        end
    end

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        match_valid = 1'b0;
        match_idx   = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_valid = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: slot file, time-change detect,
// ring/snooze/dismiss sequencing.
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          minute_tick,
    input  logic [6:0]                    cur_minutes,
    input  logic [5:0]                    cur_hours,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_ALARMS)-1:0] wr_slot,
    input  logic [6:0]                    wr_minutes,
    input  logic [5:0]                    wr_hours,
    input  logic                          wr_enable,
    input  logic [$clog2(NUM_ALARMS)-1:0] rd_slot,
    output logic [6:0]                    rd_minutes,
    output logic [5:0]                    rd_hours,
    output logic                          rd_enable,
    input  logic                          snooze_btn,
    input  logic                          dismiss_btn,
    output logic                          alarm_trigger,
    output logic                          snoozed,
    output logic [$clog2(NUM_ALARMS)-1:0] active_slot,
    output logic [2:0]                    snooze_count
);

    localparam int IDX_W = $clog2(NUM_ALARMS);
    localparam logic [5:0] RING_LIM = 6'(RING_TIMEOUT_MIN);
    localparam logic [5:0] SNZ_LEN  = 6'(SNOOZE_MIN);
    localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZE);

    alarm_slot_t [NUM_ALARMS-1:0] slots_q, slots_d;
    logic [HOUR_W+MIN_W-1:0]      time_q, time_d;
    alarm_state_t                 state_q, state_d;
    logic [IDX_W-1:0]             act_q, act_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [5:0]                   ring_q, ring_d;
    logic [5:0]                   snz_q, snz_d;

    logic             time_chg;
    logic             wr_ok;
    logic             kill;
    logic             ring_done;
    logic             match_valid;
    logic [IDX_W-1:0] match_idx;

    assign time_d   = {cur_hours, cur_minutes};
    assign time_chg = (time_d != time_q);

    assign wr_ok = wr_en && time_valid(wr_hours, wr_minutes);

    // Disabling the slot that owns the event ends the event.
    assign kill = wr_ok && !wr_enable && (wr_slot == act_q)
               && (state_q != IDLE);

    assign ring_done = minute_tick && ((ring_q + 6'd1) == RING_LIM);

    alarm_match_arbiter #(
        .NUM_ALARMS (NUM_ALARMS),
        .IDX_W      (IDX_W)
    ) u_arb (
        .slots       (slots_q),
        .cur_hours   (cur_hours),
        .cur_minutes (cur_minutes),
        .time_chg    (time_chg),
        .match_valid (match_valid),
        .match_idx   (match_idx)
    );

    always_comb begin
        slots_d = slots_q;
        if (wr_ok) begin
            slots_d[wr_slot].enable  = wr_enable;
            slots_d[wr_slot].hours   = wr_hours;
            slots_d[wr_slot].minutes = wr_minutes;
        end
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        unique case (state_q)
            IDLE: begin
                if (match_valid) begin
                    state_d = RINGING;
                    act_d   = match_idx;
                    cnt_d   = '0;
                    ring_d  = '0;
                end
            end
            RINGING: begin
                if (minute_tick) ring_d = ring_q + 6'd1;
                if (dismiss_btn || kill || ring_done) begin
                    state_d = IDLE;
                end else if (snooze_btn && (cnt_q < SNZ_MAX)) begin
                    state_d = SNOOZED;
                    cnt_d   = cnt_q + 3'd1;
                    snz_d   = SNZ_LEN;
                end
            end
            SNOOZED: begin
                if (minute_tick) snz_d = snz_q - 6'd1;
                if (dismiss_btn || kill) begin
                    state_d = IDLE;
                end else if (minute_tick && (snz_q == 6'd1)) begin
                    state_d = RINGING;
                    ring_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots_q <= '0;
            time_q  <= '0;
            state_q <= IDLE;
            act_q   <= '0;
            cnt_q   <= '0;
            ring_q  <= '0;
            snz_q   <= '0;
        end else begin
            slots_q <= slots_d;
            time_q  <= time_d;
            state_q <= state_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
        end
    end

    assign alarm_trigger = (state_q == RINGING);
    assign snoozed       = (state_q == SNOOZED);
    assign active_slot   = act_q;
    assign snooze_count  = cnt_q;

    assign rd_minutes = slots_q[rd_slot].minutes;
    assign rd_hours   = slots_q[rd_slot].hours;
    assign rd_enable  = slots_q[rd_slot].enable;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed scenarios plus a
// randomized run against a minute-level behavioural model.
module tb_alarm_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       minute_tick;
    logic [6:0] cur_minutes;
    logic [5:0] cur_hours;
    logic       wr_en;
    logic [1:0] wr_slot;
    logic [6:0] wr_minutes;
    logic [5:0] wr_hours;
    logic       wr_enable;
    logic [1:0] rd_slot;
    logic [6:0] rd_minutes;
    logic [5:0] rd_hours;
    logic       rd_enable;
    logic       snooze_btn;
    logic       dismiss_btn;
    logic       alarm_trigger;
    logic       snoozed;
    logic [1:0] active_slot;
    logic [2:0] snooze_count;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 ringing, 2 snoozed
    int m_en [4];
    int m_h  [4];
    int m_m  [4];
    int m_time, m_mode, m_slot, m_cnt, m_rung, m_left;

    always #10 clk = ~clk;

    alarm_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .minute_tick   (minute_tick),
        .cur_minutes   (cur_minutes),
        .cur_hours     (cur_hours),
        .wr_en         (wr_en),
        .wr_slot       (wr_slot),
        .wr_minutes    (wr_minutes),
        .wr_hours      (wr_hours),
        .wr_enable     (wr_enable),
        .rd_slot       (rd_slot),
        .rd_minutes    (rd_minutes),
        .rd_hours      (rd_hours),
        .rd_enable     (rd_enable),
        .snooze_btn    (snooze_btn),
        .dismiss_btn   (dismiss_btn),
        .alarm_trigger (alarm_trigger),
        .snoozed       (snoozed),
        .active_slot   (active_slot),
        .snooze_count  (snooze_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 0; m_h[i] = 0; m_m[i] = 0;
        end
        m_time = 0; m_mode = 0; m_slot = 0;
        m_cnt = 0; m_rung = 0; m_left = 0;
    endtask

    task automatic model_step();
        int now, hit;
        bit wok, kill;
        now = int'(cur_hours) * 128 + int'(cur_minutes);
        hit = -1;
        if (now != m_time)
            for (int i = 3; i >= 0; i--)
                if (m_en[i] == 1 && m_h[i] == int'(cur_hours)
                    && m_m[i] == int'(cur_minutes)) hit = i;
        wok  = wr_en && (wr_minutes < 7'd60) && (wr_hours < 6'd24);
        kill = wok && !wr_enable && int'(wr_slot) == m_slot && m_mode != 0;
        if (m_mode == 0) begin
            if (hit >= 0) begin
                m_mode = 1; m_slot = hit; m_cnt = 0; m_rung = 0;
            end
        end else if (m_mode == 1) begin
            if (minute_tick) m_rung++;
            if (dismiss_btn || kill || m_rung == 10) m_mode = 0;
            else if (snooze_btn && m_cnt < 3) begin
                m_mode = 2; m_cnt++; m_left = 5;
            end
        end else begin
            if (minute_tick) m_left--;
            if (dismiss_btn || kill) m_mode = 0;
            else if (m_left == 0) begin
                m_mode = 1; m_rung = 0;
            end
        end
        if (wok) begin
            m_en[wr_slot] = int'(wr_enable);
            m_h[wr_slot]  = int'(wr_hours);
            m_m[wr_slot]  = int'(wr_minutes);
        end
        m_time = now;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        wr_en = 1'b0; minute_tick = 1'b0;
        snooze_btn = 1'b0; dismiss_btn = 1'b0;
    endtask

    task automatic set_time(input int h, input int m);
        cur_hours = 6'(h); cur_minutes = 7'(m);
        cyc();
    endtask

    task automatic write_slot(input int s, input int h, input int m, input bit e);
        wr_en = 1'b1; wr_slot = 2'(s);
        wr_hours = 6'(h); wr_minutes = 7'(m); wr_enable = e;
        cyc();
    endtask

    task automatic tick_only();
        minute_tick = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        minute_tick = 0; cur_minutes = 0; cur_hours = 0;
        wr_en = 0; wr_slot = 0; wr_minutes = 0; wr_hours = 0;
        wr_enable = 0; rd_slot = 0; snooze_btn = 0; dismiss_btn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({alarm_trigger, snoozed, active_slot, snooze_count} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0",
                {alarm_trigger, snoozed, active_slot, snooze_count});
        end
        rd_slot = 2'd3; #1;
        checks++;
        if ({rd_enable, rd_hours, rd_minutes} !== 14'd0) begin
            errors++;
            $display("FAIL reset_slot3 got=%h exp=0", {rd_enable, rd_hours, rd_minutes});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_match();
        write_slot(1, 7, 30, 1'b1);
        set_time(7, 29);
        checks++;
        if (alarm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL match_early got=%b exp=0", alarm_trigger);
        end
        minute_tick = 1'b1;
        set_time(7, 30);
        checks++;
        if (alarm_trigger !== 1'b1 || active_slot !== 2'd1) begin
            errors++;
            $display("FAIL match_ring got=%b/%0d exp=1/1", alarm_trigger, active_slot);
        end
        dismiss_btn = 1'b1;
        cyc();
        repeat (3) cyc();
        checks++;
        if (alarm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL match_dismiss got=%b exp=0", alarm_trigger);
        end
    endtask

    task automatic test_priority();
        write_slot(1, 7, 30, 1'b0);
        write_slot(0, 6, 0, 1'b1);
        write_slot(2, 6, 0, 1'b1);
        set_time(6, 0);
        checks++;
        if (alarm_trigger !== 1'b1 || active_slot !== 2'd0) begin
            errors++;
            $display("FAIL prio_ring got=%b/%0d exp=1/0", alarm_trigger, active_slot);
        end
        dismiss_btn = 1'b1;
        cyc();
        repeat (4) cyc();
        checks++;
        if (alarm_trigger !== 1'b0 || active_slot !== 2'd0) begin
            errors++;
            $display("FAIL prio_slot2 got=%b/%0d exp=0/0", alarm_trigger, active_slot);
        end
    endtask

    task automatic test_snooze();
        write_slot(1, 7, 30, 1'b1);
        set_time(7, 29);
        set_time(7, 30);
        for (int k = 1; k <= 3; k++) begin
            snooze_btn = 1'b1;
            cyc();
            checks++;
            if (snoozed !== 1'b1 || alarm_trigger !== 1'b0) begin
                errors++;
                $display("FAIL snooze_enter%0d got=%b/%b exp=1/0", k, snoozed, alarm_trigger);
            end
            repeat (4) tick_only();
            checks++;
            if (snoozed !== 1'b1) begin
                errors++;
                $display("FAIL snooze_hold%0d got=%b exp=1", k, snoozed);
            end
            tick_only();
            checks++;
            if (alarm_trigger !== 1'b1 || snooze_count !== 3'(k)) begin
                errors++;
                $display("FAIL snooze_back%0d got=%b/%0d exp=1/%0d",
                    k, alarm_trigger, snooze_count, k);
            end
        end
        snooze_btn = 1'b1;
        cyc();
        checks++;
        if (alarm_trigger !== 1'b1 || snoozed !== 1'b0 || snooze_count !== 3'd3) begin
            errors++;
            $display("FAIL snooze_limit got=%b/%b/%0d exp=1/0/3",
                alarm_trigger, snoozed, snooze_count);
        end
        dismiss_btn = 1'b1;
        cyc();
    endtask

    task automatic test_timeout();
        set_time(7, 29);
        set_time(7, 30);
        repeat (9) tick_only();
        checks++;
        if (alarm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got=%b exp=1", alarm_trigger);
        end
        tick_only();
        checks++;
        if (alarm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL timeout_end got=%b exp=0", alarm_trigger);
        end
        repeat (6) cyc();
        checks++;
        if (alarm_trigger !== 1'b0 || snoozed !== 1'b0) begin
            errors++;
            $display("FAIL timeout_retrig got=%b/%b exp=0/0", alarm_trigger, snoozed);
        end
    endtask

    task automatic test_simultaneous();
        write_slot(3, 8, 15, 1'b1);
        set_time(8, 14);
        set_time(8, 15);
        checks++;
        if (alarm_trigger !== 1'b1 || active_slot !== 2'd3) begin
            errors++;
            $display("FAIL sim_ring got=%b/%0d exp=1/3", alarm_trigger, active_slot);
        end
        dismiss_btn = 1'b1; snooze_btn = 1'b1;
        cyc();
        checks++;
        if (alarm_trigger !== 1'b0 || snoozed !== 1'b0) begin
            errors++;
            $display("FAIL sim_dismiss got=%b/%b exp=0/0", alarm_trigger, snoozed);
        end
        set_time(8, 14);
        set_time(8, 15);
        snooze_btn = 1'b1;
        cyc();
        write_slot(3, 8, 15, 1'b0);
        rd_slot = 2'd3; #1;
        checks++;
        if (snoozed !== 1'b0 || alarm_trigger !== 1'b0 || rd_enable !== 1'b0) begin
            errors++;
            $display("FAIL sim_kill got=%b/%b/%b exp=0/0/0",
                snoozed, alarm_trigger, rd_enable);
        end
    endtask

    task automatic test_write_reject();
        write_slot(0, 5, 60, 1'b1);
        rd_slot = 2'd0; #1;
        checks++;
        if ({rd_enable, rd_hours, rd_minutes} !== {1'b1, 6'd6, 7'd0}) begin
            errors++;
            $display("FAIL reject_min got=%b/%0d/%0d exp=1/6/0", rd_enable, rd_hours, rd_minutes);
        end
        write_slot(0, 24, 10, 1'b0);
        #1;
        checks++;
        if ({rd_enable, rd_hours, rd_minutes} !== {1'b1, 6'd6, 7'd0}) begin
            errors++;
            $display("FAIL reject_hr got=%b/%0d/%0d exp=1/6/0", rd_enable, rd_hours, rd_minutes);
        end
    endtask

    task automatic test_reset_mid_ring();
        write_slot(3, 8, 15, 1'b1);
        set_time(8, 14);
        set_time(8, 15);
        checks++;
        if (alarm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL rstring_pre got=%b exp=1", alarm_trigger);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (alarm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL rstring_async got=%b exp=0", alarm_trigger);
        end
        for (int s = 0; s < 4; s++) begin
            rd_slot = 2'(s); #1;
            checks++;
            if (rd_enable !== 1'b0) begin
                errors++;
                $display("FAIL rstring_en%0d got=%b exp=0", s, rd_enable);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cur_hours = 6'd7;
                cur_minutes = 7'($urandom_range(0, 3));
            end
            minute_tick = ($urandom_range(0, 2) == 0);
            snooze_btn  = ($urandom_range(0, 5) == 0);
            dismiss_btn = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) begin
                wr_en = 1'b1;
                wr_slot = 2'($urandom_range(0, 3));
                wr_hours = ($urandom_range(0, 9) == 0) ? 6'd24 : 6'd7;
                wr_minutes = ($urandom_range(0, 9) == 0) ? 7'd60
                           : 7'($urandom_range(0, 3));
                wr_enable = ($urandom_range(0, 3) != 0);
            end
            cyc();
            checks++;
            if (alarm_trigger !== (m_mode == 1) || snoozed !== (m_mode == 2)) begin
                errors++;
                $display("FAIL rand_state n=%0d got=%b/%b exp_mode=%0d",
                    n, alarm_trigger, snoozed, m_mode);
            end
            checks++;
            if (active_slot !== 2'(m_slot) || snooze_count !== 3'(m_cnt)) begin
                errors++;
                $display("FAIL rand_slotcnt n=%0d got=%0d/%0d exp=%0d/%0d",
                    n, active_slot, snooze_count, m_slot, m_cnt);
            end
            s = $urandom_range(0, 3);
            rd_slot = 2'(s); #1;
            checks++;
            if (rd_enable !== 1'(m_en[s]) || rd_hours !== 6'(m_h[s])
                || rd_minutes !== 7'(m_m[s])) begin
                errors++;
                $display("FAIL rand_rd n=%0d slot=%0d got=%b/%0d/%0d exp=%0d/%0d/%0d",
                    n, s, rd_enable, rd_hours, rd_minutes, m_en[s], m_h[s], m_m[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_priority();
        test_snooze();
        test_timeout();
        test_simultaneous();
        test_write_reject();
        test_reset_mid_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
